// File: rtl/bitstream_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bitstream_pkg
//  Description : Shared types and default widths for the bitstream bit reader.
//  Revision    : 1.0 - initial release
// ============================================================================
package bitstream_pkg;

    // Read-side controller states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_EOS  = 2'd2
    } rd_state_e;

    // Default configuration
    localparam int DEF_DATA_W     = 8;
    localparam int DEF_FIFO_DEPTH = 8;
    localparam int DEF_MAX_BITS   = 16;

    // Widths derived from the default configuration
    localparam int ACC_W = DEF_MAX_BITS + DEF_DATA_W;
    localparam int NB_W  = $clog2(DEF_MAX_BITS + 1);
    localparam int CNT_W = $clog2(ACC_W + 1);

endpackage : bitstream_pkg
`default_nettype wire

// File: rtl/bitstream_bit_reader_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : byte_fifo
//  Description : Synchronous FIFO with registered pointers. A full FIFO
//                refuses a push even when a pop happens in the same cycle.
//                clr empties the FIFO but still honours a same-cycle push.
//  Revision    : 1.0 - initial release
// ============================================================================
module byte_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clr,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;

    logic             w_push;
    logic             w_pop;
    logic [AW-1:0]    w_wr_idx;

    assign full     = (count_q == CW'(DEPTH));
    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign pop_data = mem_q[rd_ptr_q];

    assign w_push   = push && !full;
    assign w_pop    = pop && !empty;
    // A push during clr lands in slot 0 of the freshly emptied FIFO
    assign w_wr_idx = clr ? '0 : wr_ptr_q;

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (clr) begin
            wr_ptr_q <= w_push ? AW'(1) : '0;
            rd_ptr_q <= '0;
            count_q  <= w_push ? CW'(1) : '0;
        end else begin
            if (w_push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (w_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage array, written only on an accepted push
    always_ff @(posedge clk) begin
        if (w_push && !rst) begin
            mem_q[w_wr_idx] <= push_data;
        end
    end

endmodule : byte_fifo
`default_nettype wire

// File: rtl/bitstream_bit_reader.sv
`default_nettype none
// ============================================================================
//  Module      : bitstream_bit_reader
//  Description : Byte-stream to bit-stream adapter for the arithmetic decoder.
//                Bytes go through a small FIFO into a left-aligned bit
//                accumulator; reads of 0..MAX_BITS bits are served MSB-first,
//                with zero padding once the stream is exhausted.
//  Revision    : 1.0 - initial release
// ============================================================================
module bitstream_bit_reader
    import bitstream_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 8,
    parameter int MAX_BITS   = 16
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic                                     flush,
    input  logic [DATA_W-1:0]                        in_data,
    input  logic                                     in_valid,
    input  logic                                     in_last,
    output logic                                     in_ready,
    input  logic                                     rd_req,
    input  logic [$clog2(MAX_BITS+1)-1:0]            rd_nbits,
    output logic                                     rd_busy,
    output logic                                     rd_valid,
    output logic [MAX_BITS-1:0]                      rd_data,
    output logic                                     rd_eos,
    output logic [$clog2(MAX_BITS+DATA_W+1)-1:0]     bits_avail
);

    localparam int ACC_BITS  = MAX_BITS + DATA_W;
    localparam int NB_BITS   = $clog2(MAX_BITS + 1);
    localparam int CNT_BITS  = $clog2(ACC_BITS + 1);
    localparam int FCNT_BITS = $clog2(FIFO_DEPTH + 1);

    // Controller state
    rd_state_e             state_q, state_d;
    logic [CNT_BITS-1:0]   n_q, n_d;

    // Accumulator: left-aligned, cnt_q valid bits, everything below is zero
    logic [ACC_BITS-1:0]   acc_q, acc_d;
    logic [CNT_BITS-1:0]   cnt_q, cnt_d;
    logic                  last_seen_q, last_seen_d;

    // Registered response
    logic                  rd_valid_q, rd_valid_d;
    logic [MAX_BITS-1:0]   rd_data_q, rd_data_d;
    logic                  rd_eos_q, rd_eos_d;

    // FIFO interface
    logic                  w_fifo_full;
    logic                  w_fifo_empty;
    logic [FCNT_BITS-1:0]  w_fifo_count;
    logic [DATA_W-1:0]     w_fifo_rdata;
    logic                  w_accept;
    logic                  w_pop;

    // Datapath helpers
    logic [CNT_BITS-1:0]   w_n_req;
    logic [CNT_BITS-1:0]   w_n_sel;
    logic                  w_serve;
    logic                  w_pad;
    logic                  w_eos_reached;
    logic [CNT_BITS-1:0]   w_consume;
    logic [CNT_BITS-1:0]   w_cnt_cons;
    logic [ACC_BITS-1:0]   w_acc_cons;
    logic [MAX_BITS-1:0]   w_top;
    logic [CNT_BITS-1:0]   w_shift;

    assign in_ready    = !rst && !w_fifo_full && !last_seen_q;
    assign w_accept    = in_valid && in_ready;
    assign last_seen_d = last_seen_q || (w_accept && in_last);

    // An empty FIFO means nothing can be popped, so no byte is in flight
    assign w_eos_reached = last_seen_q && (w_fifo_count == '0);

    // Oversized requests are clamped to the widest legal read
    assign w_n_req = (rd_nbits > NB_BITS'(MAX_BITS)) ? CNT_BITS'(MAX_BITS)
                                                     : CNT_BITS'(rd_nbits);

    assign rd_busy    = (state_q == ST_WAIT);
    assign rd_valid   = rd_valid_q;
    assign rd_data    = rd_data_q;
    assign rd_eos     = rd_eos_q;
    assign bits_avail = cnt_q;

    byte_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .clr       (flush),
        .push      (w_accept),
        .push_data (in_data),
        .pop       (w_pop),
        .pop_data  (w_fifo_rdata),
        .full      (w_fifo_full),
        .empty     (w_fifo_empty),
        .count     (w_fifo_count)
    );

    // Request controller: decide whether to serve now, wait, or pad
    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        w_serve = 1'b0;
        w_pad   = 1'b0;
        w_n_sel = n_q;
        case (state_q)
            ST_IDLE: begin
                if (rd_req) begin
                    w_n_sel = w_n_req;
                    if (cnt_q >= w_n_req) begin
                        w_serve = 1'b1;
                    end else if (w_eos_reached) begin
                        w_serve = 1'b1;
                        w_pad   = 1'b1;
                        state_d = ST_EOS;
                    end else begin
                        n_d     = w_n_req;
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q >= n_q) begin
                    w_serve = 1'b1;
                    state_d = ST_IDLE;
                end else if (w_eos_reached) begin
                    w_serve = 1'b1;
                    w_pad   = 1'b1;
                    state_d = ST_EOS;
                end
            end
            ST_EOS: begin
                // Accumulator is already empty; every read returns zeros
                if (rd_req) begin
                    w_n_sel = w_n_req;
                    w_serve = 1'b1;
                    w_pad   = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Accumulator update: consume the served bits first, then refill one byte
    always_comb begin
        w_consume = '0;
        if (w_serve) begin
            w_consume = w_pad ? cnt_q : w_n_sel;
        end
        w_cnt_cons = cnt_q - w_consume;
        w_acc_cons = acc_q << w_consume;
        w_pop      = !w_fifo_empty && (w_cnt_cons <= CNT_BITS'(MAX_BITS));
        acc_d      = w_acc_cons;
        cnt_d      = w_cnt_cons;
        if (w_pop) begin
            acc_d = w_acc_cons | ({w_fifo_rdata, {MAX_BITS{1'b0}}} >> w_cnt_cons);
            cnt_d = w_cnt_cons + CNT_BITS'(DATA_W);
        end

        // Top n bits right-aligned; zero bits below cnt give the padding
        w_top      = acc_q[ACC_BITS-1 -: MAX_BITS];
        w_shift    = CNT_BITS'(MAX_BITS) - w_n_sel;
        rd_valid_d = w_serve;
        rd_data_d  = rd_data_q;
        rd_eos_d   = rd_eos_q;
        if (w_serve) begin
            rd_data_d = w_top >> w_shift;
            rd_eos_d  = w_pad;
        end
    end

    // State, accumulator and response registers; flush clears like reset
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            state_q     <= ST_IDLE;
            n_q         <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            last_seen_q <= w_accept && in_last;
            rd_valid_q  <= 1'b0;
            rd_data_q   <= '0;
            rd_eos_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            n_q         <= n_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            last_seen_q <= last_seen_d;
            rd_valid_q  <= rd_valid_d;
            rd_data_q   <= rd_data_d;
            rd_eos_q    <= rd_eos_d;
        end
    end

endmodule : bitstream_bit_reader
`default_nettype wire

// File: tb/tb_bitstream_bit_reader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bitstream_bit_reader
//  Description : Scoreboard bench for bitstream_bit_reader.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bitstream_bit_reader;

    localparam int DATA_W     = 8;
    localparam int FIFO_DEPTH = 8;
    localparam int MAX_BITS   = 16;

    typedef struct {
        logic [15:0] data;
        logic        eos;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic [7:0]  in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_last = 1'b0;
    logic        in_ready;
    logic        rd_req = 1'b0;
    logic [4:0]  rd_nbits = '0;
    logic        rd_busy;
    logic        rd_valid;
    logic [15:0] rd_data;
    logic        rd_eos;
    logic [4:0]  bits_avail;

    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;
    int   n_valid = 0;
    int   last_valid_cyc = 0;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    bitstream_bit_reader #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH),
        .MAX_BITS   (MAX_BITS)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_last    (in_last),
        .in_ready   (in_ready),
        .rd_req     (rd_req),
        .rd_nbits   (rd_nbits),
        .rd_busy    (rd_busy),
        .rd_valid   (rd_valid),
        .rd_data    (rd_data),
        .rd_eos     (rd_eos),
        .bits_avail (bits_avail)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Response monitor: every rd_valid pulse is matched against the scoreboard
    always @(negedge clk) begin
        if (rd_valid) begin
            n_valid++;
            last_valid_cyc = cyc;
            if (exp_q.size() == 0) begin
                check("unexpected_rd_valid", 1, 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("rd_data", rd_data, e.data);
                check("rd_eos", rd_eos, e.eos);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_byte(input logic [7:0] b, input logic last);
        int t = 0;
        in_data  = b;
        in_valid = 1'b1;
        in_last  = last;
        while (!in_ready && t < 50) begin
            step(1);
            t++;
        end
        if (!in_ready) check("push_timeout", 1, 0);
        step(1);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic do_read(input int n, input logic [15:0] ed, input logic ee, input bit expect_resp);
        int t = 0;
        while (rd_busy && t < 100) begin
            step(1);
            t++;
        end
        if (rd_busy) check("busy_timeout", 1, 0);
        if (expect_resp) exp_q.push_back('{data: ed, eos: ee});
        rd_req   = 1'b1;
        rd_nbits = 5'(n);
        step(1);
        rd_req   = 1'b0;
    endtask

    task automatic wait_done();
        int t = 0;
        while ((exp_q.size() != 0 || rd_busy) && t < 100) begin
            step(1);
            t++;
        end
        if (t >= 100) check("resp_timeout", exp_q.size(), 0);
        step(1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int a;
        int accepted;
        int nv;
        int t;

        // Reset state
        step(3);
        check("rst_in_ready", in_ready, 0);
        check("rst_rd_valid", rd_valid, 0);
        check("rst_rd_data", rd_data, 0);
        check("rst_rd_eos", rd_eos, 0);
        check("rst_rd_busy", rd_busy, 0);
        check("rst_bits_avail", bits_avail, 0);
        rst = 1'b0;
        step(1);
        check("post_rst_in_ready", in_ready, 1);

        // 1: two bytes, read 9 then 7
        push_byte(8'hA5, 1'b0);
        push_byte(8'h3C, 1'b0);
        step(2);
        check("t1_bits_avail_16", bits_avail, 16);
        do_read(9, 16'h014A, 1'b0, 1'b1);
        do_read(7, 16'h003C, 1'b0, 1'b1);
        wait_done();
        check("t1_bits_avail_0", bits_avail, 0);

        // 2: underflow stall, byte arrives later
        do_read(8, 16'h00FF, 1'b0, 1'b1);
        check("t2_busy", rd_busy, 1);
        check("t2_no_valid", rd_valid, 0);
        step(3);
        check("t2_still_busy", rd_busy, 1);
        push_byte(8'hFF, 1'b0);
        a = cyc;
        wait_done();
        check("t2_latency", last_valid_cyc - a, 2);
        check("t2_busy_clear", rd_busy, 0);

        // 3: end of stream padding
        push_byte(8'h80, 1'b1);
        step(2);
        check("t3_in_ready_low", in_ready, 0);
        do_read(12, 16'h0800, 1'b1, 1'b1);
        do_read(1, 16'h0000, 1'b1, 1'b1);
        wait_done();
        check("t3_eos_held", rd_eos, 1);
        check("t3_in_ready_still_low", in_ready, 0);
        flush = 1'b1;
        step(1);
        flush = 1'b0;
        check("t3_flush_in_ready", in_ready, 1);
        check("t3_flush_eos", rd_eos, 0);
        check("t3_flush_bits", bits_avail, 0);

        // 4: fill all buffering, then free space with one read
        accepted = 0;
        in_valid = 1'b1;
        in_data  = 8'h10;
        for (int c = 0; c < 30; c++) begin
            if (in_ready) begin
                accepted++;
                step(1);
                in_data = 8'(8'h10 + accepted);
            end else begin
                step(1);
            end
        end
        in_valid = 1'b0;
        check("t4_accepted", accepted, 11);
        check("t4_in_ready_full", in_ready, 0);
        check("t4_bits_avail", bits_avail, 24);
        do_read(16, 16'h1011, 1'b0, 1'b1);
        t = 0;
        while (!in_ready && t < 2) begin
            step(1);
            t++;
        end
        check("t4_in_ready_reopen", in_ready, 1);
        do_read(16, 16'h1213, 1'b0, 1'b1);
        do_read(16, 16'h1415, 1'b0, 1'b1);
        do_read(16, 16'h1617, 1'b0, 1'b1);
        do_read(16, 16'h1819, 1'b0, 1'b1);
        do_read(8, 16'h001A, 1'b0, 1'b1);
        wait_done();
        check("t4_drained", bits_avail, 0);

        // 5: reset while a request waits
        do_read(8, 16'h0000, 1'b0, 1'b0);
        check("t5_busy", rd_busy, 1);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        check("t5_busy_dropped", rd_busy, 0);
        check("t5_bits_avail", bits_avail, 0);
        nv = n_valid;
        step(5);
        check("t5_no_valid", n_valid, nv);
        push_byte(8'h5A, 1'b0);
        do_read(8, 16'h005A, 1'b0, 1'b1);
        wait_done();

        // 6: zero-bit and oversized requests
        push_byte(8'hC3, 1'b0);
        step(3);
        check("t6_bits_8", bits_avail, 8);
        do_read(0, 16'h0000, 1'b0, 1'b1);
        wait_done();
        check("t6_bits_unchanged", bits_avail, 8);
        push_byte(8'h12, 1'b0);
        push_byte(8'h34, 1'b0);
        step(3);
        check("t6_bits_24", bits_avail, 24);
        do_read(20, 16'hC312, 1'b0, 1'b1);
        wait_done();
        check("t6_bits_after_clamp", bits_avail, 8);
        do_read(8, 16'h0034, 1'b0, 1'b1);
        wait_done();
        check("t6_scoreboard_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_bitstream_bit_reader
`default_nettype wire

// File: doc/bitstream_bit_reader.md
Name: bitstream_bit_reader

Overview:
- Synthesizable, parametrised bitstream source for the VVC arithmetic decoder.
- Accepts bytes from an upstream valid/ready stream and buffers them in a byte FIFO plus a bit accumulator.
- Serves MSB-first reads of 0..MAX_BITS bits per request; covers the 9-bit range init and variable renormalisation reads.
- Handles stalls on underflow and end of stream, returning zero-padding once the stream is exhausted.

Parameters:
- DATA_W, 8: input word width in bits.
- FIFO_DEPTH, 8: byte FIFO entries; power of 2, minimum 2.
- MAX_BITS, 16: maximum bits per read; must be >= DATA_W.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- flush  in  1  synchronous clear of all buffered data and EOS state; priority below rst.
- in_data  in  DATA_W  upstream byte.
- in_valid  in  1  in_data valid.
- in_last  in  1  marks in_data as the final byte of the stream.
- in_ready  out  1  byte accepted when in_valid && in_ready.
- rd_req  in  1  read request pulse; accepted only when rd_busy=0.
- rd_nbits  in  $clog2(MAX_BITS+1)  bits requested.
- rd_busy  out  1  a request is pending.
- rd_valid  out  1  one-cycle pulse; rd_data is valid.
- rd_data  out  MAX_BITS  requested bits, right-aligned, zero-extended.
- rd_eos  out  1  the response included zero-padding past end of stream.
- bits_avail  out  $clog2(MAX_BITS+DATA_W+1)  accumulator bit count.

Behaviour:
- Reset (rst=1 at clk edge):
  - FIFO empty, accumulator cleared.
  - rd_valid=0, rd_data=0, rd_eos=0, rd_busy=0, bits_avail=0.
  - State IDLE, last_seen=0.
  - in_ready=0 while rst=1.
- flush: same clearing as reset; in_ready may be 1 in the same cycle.
- Input side:
  - in_ready = !fifo_full && !last_seen.
  - Accepting a byte with in_last=1 sets last_seen, so in_ready stays 0 until rst/flush.
  - No bypass: a full FIFO refuses input even if it pops in the same cycle.
- Accumulator:
  - Width ACC_W = MAX_BITS + DATA_W, left-aligned, cnt bits valid.
  - Each cycle, consumption of the served read is applied first.
  - Then, if post-consume cnt <= MAX_BITS and the FIFO is non-empty, one byte is popped and appended below the valid bits.
  - At most one pop per cycle.
- Requests:
  - rd_nbits > MAX_BITS is clamped to MAX_BITS.
  - rd_nbits = 0 returns rd_data=0, consumes nothing, and answers next cycle.
  - While rd_busy=1, rd_req is ignored.
- FSM:
  - IDLE, rd_req:
    - If cnt >= n: serve. rd_valid=1 next cycle, rd_data = top n bits, cnt -= n.
    - Else if eos_reached: go to EOS handling (below).
    - Else: latch n, go to WAIT, rd_busy=1.
  - WAIT: each cycle re-evaluate with the registered cnt.
    - If cnt >= n: serve next cycle and return to IDLE.
    - Else if eos_reached: serve with padding.
  - EOS handling (sticky until rst/flush):
    - The remaining cnt bits go in the MSBs of the n-bit result, followed by zeros.
    - Response has rd_eos=1 and cnt becomes 0.
    - All later reads return 0 with rd_eos=1.
- eos_reached = last_seen && fifo_empty && no pop in progress.
- Latency:
  - rd_req at T with enough bits gives rd_valid at T+1.
  - A byte accepted at T is in the FIFO at T+1 and in the accumulator at T+2.
  - A pending request then sees rd_valid at T+3.
- rst or flush in WAIT: the request is dropped and no rd_valid is issued.
- Total buffering is FIFO_DEPTH + ACC_W/DATA_W bytes (11 bytes with defaults).

Decomposition:
- Shared package bitstream_pkg:
  - FSM state enum (IDLE, WAIT, EOS).
  - Width localparams ACC_W, NB_W, CNT_W.
- One sub-module: byte_fifo.
  - Synchronous FIFO, DEPTH/WIDTH parameters.
  - Ports push/pop/full/empty/count; same rst.

Test Plan:
1. Push 0xA5, 0x3C; rd 9 bits -> rd_data=0x14A; then rd 7 bits -> rd_data=0x3C, bits_avail=0.
2. FIFO empty, rd_req nbits=8 -> rd_busy=1 with no rd_valid. Push 0xFF at T -> rd_valid at T+3, rd_data=0xFF, rd_busy=0.
3. Push 0x80 with in_last, then rd 12 -> rd_data=0x800, rd_eos=1, in_ready=0. A following rd of 1 bit -> rd_data=0, rd_eos=1. flush -> in_ready=1, rd_eos clears.
4. Push continuously with no reads -> exactly 11 bytes accepted, then in_ready=0. A rd of 16 bits -> in_ready returns to 1 within 2 cycles.
5. Request pending in WAIT, pulse rst for 1 cycle -> no rd_valid, rd_busy=0, bits_avail=0. A subsequent push/read works normally.
6. Edge requests:
   - rd_nbits=0 -> rd_valid, rd_data=0, bits_avail unchanged.
   - rd_nbits=20 with 24 bits buffered -> 16 bits returned, bits_avail=8.
